// File: rtl/delay_ctrl_pkg.sv
// Shared constants for the delay-line sequencer: state encoding and RAM read latency.
package delay_ctrl_pkg;

    localparam int STATE_W = 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_FLUSH = 2'd3;

    localparam int RAM_RD_LATENCY = 1;

endpackage

// File: rtl/ram_2port.sv
// Simple dual-port RAM: port A writes, port B reads with one registered cycle of latency.
module ram_2port #(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 6
) (
    input  logic              clka,
    input  logic              wea,
    input  logic [AWIDTH-1:0] addra,
    input  logic [DWIDTH-1:0] dia,
    input  logic              clkb,
    input  logic              enb,
    input  logic [AWIDTH-1:0] addrb,
    output logic [DWIDTH-1:0] dob
);

    logic [DWIDTH-1:0] mem [2**AWIDTH];

    always_ff @(posedge clka) begin
        if (wea) begin
            mem[addra] <= dia;
        end
    end

    always_ff @(posedge clkb) begin
        if (enb) begin
            dob <= mem[addrb];
        end
    end

endmodule

// File: rtl/delay_line_ctrl.sv
// Address/enable sequencer turning an external dual-port RAM into a programmable
// D-sample delay line; tracks fill level and flags when the RAM output is valid.
module delay_line_ctrl
    import delay_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int AWIDTH        = 6,
    parameter int DEFAULT_DELAY = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [AWIDTH-1:0]     cfg_delay,
    input  logic                  cfg_load,
    output logic                  cfg_err,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  input_valid,
    output logic                  in_drop,
    output logic                  ram_wea,
    output logic [AWIDTH-1:0]     ram_addra,
    output logic [DATA_WIDTH-1:0] ram_dia,
    output logic                  ram_enb,
    output logic [AWIDTH-1:0]     ram_addrb,
    input  logic [DATA_WIDTH-1:0] ram_dob,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  output_valid,
    output logic [AWIDTH-1:0]     delay_q,
    output logic [STATE_W-1:0]    state_o
);

    logic [STATE_W-1:0]        state_reg;
    logic [AWIDTH-1:0]         wr_ptr_reg;
    logic [AWIDTH-1:0]         fill_cnt_reg;
    logic [AWIDTH-1:0]         delay_reg;
    logic                      cfg_err_reg;
    logic                      in_drop_reg;
    logic [RAM_RD_LATENCY-1:0] rd_pipe_reg;

    logic              cfg_ok;
    logic              active;
    logic              accept;
    logic [AWIDTH-1:0] fill_next;

    // A zero delay is rejected outright; it neither flushes nor blocks the sample.
    assign cfg_ok    = cfg_load && (cfg_delay != '0);
    assign active    = (state_reg == ST_FILL) || (state_reg == ST_RUN);
    assign accept    = enable && input_valid && active && !cfg_ok;
    assign fill_next = fill_cnt_reg + 1'b1;

    assign ram_wea   = accept;
    assign ram_addra = wr_ptr_reg;
    assign ram_dia   = data_in;
    assign ram_enb   = accept && (state_reg == ST_RUN);
    assign ram_addrb = wr_ptr_reg - delay_reg;

    assign data_out     = ram_dob;
    assign output_valid = rd_pipe_reg[RAM_RD_LATENCY-1];
    assign delay_q      = delay_reg;
    assign state_o      = state_reg;
    assign cfg_err      = cfg_err_reg;
    assign in_drop      = in_drop_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= ST_IDLE;
            wr_ptr_reg   <= '0;
            fill_cnt_reg <= '0;
            delay_reg    <= AWIDTH'(DEFAULT_DELAY);
            cfg_err_reg  <= 1'b0;
            in_drop_reg  <= 1'b0;
            rd_pipe_reg  <= '0;
        end else begin
            cfg_err_reg <= cfg_load && (cfg_delay == '0);
            in_drop_reg <= input_valid && !accept;

            // Valid tracks the RAM read pipeline so data_out and output_valid line up.
            rd_pipe_reg[0] <= ram_enb;
            for (int i = 1; i < RAM_RD_LATENCY; i++) begin
                rd_pipe_reg[i] <= rd_pipe_reg[i-1];
            end

            if (cfg_ok) begin
                delay_reg <= cfg_delay;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (!cfg_ok && enable) begin
                        state_reg <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (cfg_ok) begin
                        state_reg <= ST_FLUSH;
                    end else if (accept) begin
                        wr_ptr_reg   <= wr_ptr_reg + 1'b1;
                        fill_cnt_reg <= fill_next;
                        if (fill_next == delay_reg) begin
                            state_reg <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (cfg_ok) begin
                        state_reg <= ST_FLUSH;
                    end else if (accept) begin
                        wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    end
                end
                default: begin
                    wr_ptr_reg   <= '0;
                    fill_cnt_reg <= '0;
                    state_reg    <= ST_FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Randomized bench for delay_line_ctrl with a RAM beside it; a queue-based model of
// the delay line predicts every output, drop, error pulse and RAM access.
module tb_delay_line_ctrl;

    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          enable;
    logic [AW-1:0] cfg_delay;
    logic          cfg_load;
    logic          cfg_err;
    logic [DW-1:0] data_in;
    logic          input_valid;
    logic          in_drop;
    logic          ram_wea;
    logic [AW-1:0] ram_addra;
    logic [DW-1:0] ram_dia;
    logic          ram_enb;
    logic [AW-1:0] ram_addrb;
    logic [DW-1:0] ram_dob;
    logic [DW-1:0] data_out;
    logic          output_valid;
    logic [AW-1:0] delay_q;
    logic [1:0]    state_o;

    always #5 clock = ~clock;

    delay_line_ctrl #(.DATA_WIDTH(DW), .AWIDTH(AW), .DEFAULT_DELAY(8)) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable),
        .cfg_delay(cfg_delay), .cfg_load(cfg_load), .cfg_err(cfg_err),
        .data_in(data_in), .input_valid(input_valid), .in_drop(in_drop),
        .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dia(ram_dia),
        .ram_enb(ram_enb), .ram_addrb(ram_addrb), .ram_dob(ram_dob),
        .data_out(data_out), .output_valid(output_valid),
        .delay_q(delay_q), .state_o(state_o)
    );

    ram_2port #(.DWIDTH(DW), .AWIDTH(AW)) ram (
        .clka(clock), .wea(ram_wea), .addra(ram_addra), .dia(ram_dia),
        .clkb(clock), .enb(ram_enb), .addrb(ram_addrb), .dob(ram_dob)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: samples accepted since the last flush, in arrival order.
    logic [DW-1:0] hist[$];
    bit            m_idle;
    bit            m_flush;
    int            m_d;
    bit            exp_ov;
    logic [DW-1:0] exp_out;
    bit            exp_drop;
    bit            exp_err;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        m_idle   = 1'b1;
        m_flush  = 1'b0;
        m_d      = 8;
        exp_ov   = 1'b0;
        exp_out  = '0;
        exp_drop = 1'b0;
        exp_err  = 1'b0;
    endtask

    function automatic int model_state();
        if (m_idle)  return 0;
        if (m_flush) return 3;
        return (hist.size() >= m_d) ? 2 : 1;
    endfunction

    // Called at a falling edge: check last edge's results, apply inputs, predict next edge.
    task automatic cycle(input bit en, input bit iv, input logic [DW-1:0] din,
                         input bit ld, input logic [AW-1:0] cd);
        bit valid_ld, acc, rd;
        int sz;
        check_val("output_valid", output_valid, exp_ov);
        if (exp_ov) begin
            check_val("data_out", data_out, exp_out);
            $display("out sample=0x%04h delay=%0d", data_out, m_d);
        end
        check_val("in_drop", in_drop, exp_drop);
        check_val("cfg_err", cfg_err, exp_err);
        check_val("delay_q", delay_q, m_d);
        check_val("state_o", state_o, model_state());

        enable = en; input_valid = iv; data_in = din; cfg_load = ld; cfg_delay = cd;
        #1;
        sz       = hist.size();
        valid_ld = ld && (cd != 0);
        acc      = en && iv && !m_idle && !m_flush && !valid_ld;
        rd       = acc && (sz >= m_d);
        check_val("ram_wea", ram_wea, acc);
        check_val("ram_enb", ram_enb, rd);
        if (acc) begin
            check_val("ram_addra", ram_addra, sz % DEPTH);
            check_val("ram_dia", ram_dia, din);
        end
        if (rd) check_val("ram_addrb", ram_addrb, (sz - m_d) % DEPTH);

        exp_ov   = rd;
        exp_out  = rd ? hist[sz - m_d] : '0;
        exp_drop = iv && !acc;
        exp_err  = ld && (cd == 0);
        if (m_flush) begin
            m_flush = 1'b0;
            if (valid_ld) m_d = cd;
        end else if (m_idle) begin
            if (valid_ld) m_d = cd;
            else if (en) m_idle = 1'b0;
        end else if (valid_ld) begin
            m_d     = cd;
            m_flush = 1'b1;
            hist.delete();
        end else if (acc) begin
            hist.push_back(din);
        end

        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic reset_now();
        reset_n = 1'b0;
        #1;
        check_val("rst_output_valid", output_valid, 0);
        check_val("rst_state_o", state_o, 0);
        check_val("rst_delay_q", delay_q, 8);
        check_val("rst_in_drop", in_drop, 0);
        model_reset();
        enable = 0; input_valid = 0; cfg_load = 0; cfg_delay = '0; data_in = '0;
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic reconfigure(input logic [AW-1:0] d);
        cycle(1, 0, '0, 1, d);
        cycle(1, 0, '0, 0, '0);
    endtask

    initial begin
        reset_n = 1'b0;
        enable = 0; input_valid = 0; cfg_load = 0; cfg_delay = '0; data_in = '0;
        model_reset();
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_val("reset_state", state_o, 0);
        check_val("reset_delay", delay_q, 8);
        check_val("reset_valid", output_valid, 0);
        check_val("reset_wea", ram_wea, 0);
        check_val("reset_enb", ram_enb, 0);
        reset_n = 1'b1;

        // T1: default delay 8, sequential samples
        cycle(1, 0, '0, 0, '0);
        for (int i = 1; i <= 20; i++) cycle(1, 1, DW'(i), 0, '0);

        // T2: maximum delay, wrapping pointers
        reconfigure(4'd15);
        for (int i = 0; i < 40; i++) cycle(1, 1, DW'($urandom), 0, '0);

        // T3: bursty input with delay 3
        reconfigure(4'd3);
        for (int i = 0; i < 40; i++) cycle(1, (i % 3) == 0, DW'($urandom), 0, '0);

        // T4: reload to 2 coincident with a sample while running at 4
        reconfigure(4'd4);
        for (int i = 0; i < 8; i++) cycle(1, 1, DW'($urandom), 0, '0);
        cycle(1, 1, DW'($urandom), 1, 4'd2);
        cycle(1, 1, DW'($urandom), 0, '0);
        for (int i = 0; i < 8; i++) cycle(1, 1, DW'($urandom), 0, '0);

        // T5: zero delay rejected, stream continues
        cycle(1, 1, DW'($urandom), 1, 4'd0);
        for (int i = 0; i < 8; i++) cycle(1, 1, DW'($urandom), 0, '0);

        // T6: pause during fill, then reset mid-run
        reconfigure(4'd5);
        for (int i = 0; i < 2; i++) cycle(1, 1, DW'($urandom), 0, '0);
        for (int i = 0; i < 5; i++) cycle(0, 1, DW'($urandom), 0, '0);
        for (int i = 0; i < 8; i++) cycle(1, 1, DW'($urandom), 0, '0);
        reset_now();

        // Random soak
        cycle(1, 0, '0, 0, '0);
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom % 8) != 0, $urandom % 2, DW'($urandom),
                  ($urandom % 25) == 0, AW'($urandom));
        end
        cycle(1, 0, '0, 0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
